// File: rtl/debounce_sync.sv
// Debounces a raw bouncing input into a clean level q with one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the stability counter.
module debounce_sync #(
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter logic        RST_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Count value on which the next enabled cycle qualifies the change.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             s;

`ifdef DEBOUNCE_SYNC_EN
   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         s    <= RST_VAL;
      end else begin
         meta <= din;
         s    <= meta;
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) s <= RST_VAL;
      else      s <= din;
   end
`endif

   // Stability FSM: a candidate level must persist for STABLE_CYCLES enabled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= RST_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE: begin
               if (s != q) begin
                  // cnt is 0 here, so this only matches when STABLE_CYCLES == 1
                  if (en && (cnt == LAST)) begin
                     q    <= s;
                     rise <= s;
                     fall <= ~s;
                  end else begin
                     state <= COUNT;
                     if (en) begin
                        cnt  <= CNT_W'(1);
                        busy <= 1'b1;
                     end
                  end
               end
            end
            COUNT: begin
               if (s == q) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (en) begin
                  if (cnt == LAST) begin
                     state <= IDLE;
                     cnt   <= '0;
                     busy  <= 1'b0;
                     q     <= s;
                     rise  <= s;
                     fall  <= ~s;
                  end else begin
                     cnt  <= cnt + CNT_W'(1);
                     busy <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_s_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(s));
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync (STABLE_CYCLES=4, plus a STABLE_CYCLES=1 instance).
module tb_debounce_sync;

`ifdef DEBOUNCE_SYNC_EN
   localparam int L = 1;
`else
   localparam int L = 0;
`endif

   logic clk, rst, en, din;
   logic q, rise, fall, busy;
   logic q1, rise1, fall1, busy1;

   int tests = 0;
   int fails = 0;

   debounce_sync #(.CNT_W(4), .STABLE_CYCLES(4), .RST_VAL(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .q(q), .rise(rise), .fall(fall), .busy(busy)
   );

   debounce_sync #(.CNT_W(4), .STABLE_CYCLES(1), .RST_VAL(1'b0)) dut1 (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int k, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s step=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic check4(input string tag, input int k, input logic eq, input logic er,
                         input logic ef, input logic eb);
      check({tag, ".q"},    k, q,    eq);
      check({tag, ".rise"}, k, rise, er);
      check({tag, ".fall"}, k, fall, ef);
      check({tag, ".busy"}, k, busy, eb);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      din = 1'b1;
      #2 rst = 1'b0;

      // Reset held with din=1
      for (int k = 1; k <= 3; k++) begin
         tick();
         check4("reset", k, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      din = 1'b0;
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check4("post_reset", k, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Clean rise; dut1 qualifies on the first enabled cycle after sampling
      din = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check4("rise", k, k >= 5 + L, k == 5 + L, 1'b0, (k >= 2 + L) && (k < 5 + L));
         check("rise1.q",    k, q1,    k >= 2 + L);
         check("rise1.rise", k, rise1, k == 2 + L);
         check("rise1.busy", k, busy1, 1'b0);
      end

      // Clean fall from q=1
      din = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check4("fall", k, k < 5 + L, 1'b0, k == 5 + L, (k >= 2 + L) && (k < 5 + L));
      end

      // Glitch of 3 samples is rejected
      for (int k = 1; k <= 8; k++) begin
         din = (k <= 3);
         tick();
         check4("glitch", k, 1'b0, 1'b0, 1'b0, (k >= 2 + L) && (k <= 4 + L));
      end

      // Enable gating: counter advances only on enabled edges
      din = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         en = ((k + L) % 2 == 0);
         tick();
         check4("enable", k, k >= 8 + L, k == 8 + L, 1'b0, (k >= 2 + L) && (k < 8 + L));
      end
      en  = 1'b1;
      din = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      check("restore.q", 0, q, 1'b0);

      // Reset mid-count discards the pending change
      din = 1'b1;
      for (int k = 1; k <= 3 + L; k++) tick();
      check("midcnt.busy_before", 0, busy, 1'b1);
      rst = 1'b0;
      #2;
      check("midcnt.q_async",    0, q,    1'b0);
      check("midcnt.busy_async", 0, busy, 1'b0);
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check4("midcnt", k, k >= 5 + L, k == 5 + L, 1'b0, (k >= 2 + L) && (k < 5 + L));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
